// File: rtl/alarm_bank_pkg.sv
// Shared encodings, field widths and helpers for the alarm_bank slice.
package alarm_bank_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  // SNOOZE is only reachable when ALARM_SNOOZE_EN is defined.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EDIT_H  = 3'd1,
    EDIT_M  = 3'd2,
    RINGING = 3'd3,
    SNOOZE  = 3'd4
  } state_t;

  // +/-1 with wrap between 0 and max; hour values are zero-extended by the caller.
  function automatic logic [MIN_W-1:0] step_wrap(input logic [MIN_W-1:0] v,
                                                 input logic [MIN_W-1:0] max,
                                                 input logic             dec);
    if (dec) return (v == '0) ? max : v - 1'b1;
    return (v == max) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Time/button inputs and ring/edit outputs of alarm_bank bundled as one port.
// master = time source / buttons / consumers side, slave = alarm_bank.
interface alarm_bank_if import alarm_bank_pkg::*; #(
  parameter int NUM_ALARMS = 4
);
  localparam int IDX_W = $clog2(NUM_ALARMS);

  logic                  sec_tick;
  logic [HOUR_W-1:0]     hour;
  logic [MIN_W-1:0]      minute;
  logic [SEC_W-1:0]      second;
  logic                  up, down, left, right, middle;
  logic                  ring;
  logic [IDX_W-1:0]      ring_idx;
  logic [IDX_W-1:0]      sel_idx;
  logic [NUM_ALARMS-1:0] alarm_en;
  logic                  edit_active;
  logic                  edit_field;
  logic [HOUR_W-1:0]     edit_hour;
  logic [MIN_W-1:0]      edit_minute;

  modport master (
    output sec_tick, hour, minute, second, up, down, left, right, middle,
    input  ring, ring_idx, sel_idx, alarm_en, edit_active, edit_field,
           edit_hour, edit_minute
  );

  modport slave (
    input  sec_tick, hour, minute, second, up, down, left, right, middle,
    output ring, ring_idx, sel_idx, alarm_en, edit_active, edit_field,
           edit_hour, edit_minute
  );

endinterface

// File: rtl/alarm_bank_match.sv
// Combinational H:M compare of every enabled alarm against the current time;
// reports whether any alarm hits and the lowest hitting index.
module alarm_bank_match import alarm_bank_pkg::*; #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_ALARMS-1:0][HOUR_W-1:0] al_hour,
  input  logic [NUM_ALARMS-1:0][MIN_W-1:0]  al_min,
  input  logic [NUM_ALARMS-1:0]             en,
  input  logic [HOUR_W-1:0]                 hour,
  input  logic [MIN_W-1:0]                  minute,
  output logic                              hit,
  output logic [IDX_W-1:0]                  idx
);

  logic [NUM_ALARMS-1:0] eq;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_cmp
    assign eq[i] = en[i] && (al_hour[i] == hour) && (al_min[i] == minute);
  end

  // Scan high to low so the lowest hitting channel is the last one written.
  always_comb begin
    hit = |eq;
    idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (eq[i]) idx = IDX_W'(i);
  end

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel H:M alarm controller with per-alarm enable and ring timeout.
// Optional snooze is compiled in with `define ALARM_SNOOZE_EN.
module alarm_bank import alarm_bank_pkg::*; #(
  parameter int NUM_ALARMS   = 4,
  parameter int RING_SECONDS = 60,
  parameter int SNOOZE_MIN   = 5
) (
  input logic         clk,
  input logic         rst_n,
  alarm_bank_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_ALARMS);
  localparam int RCNT_W = $clog2(RING_SECONDS + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_ALARMS - 1);
  localparam logic [RCNT_W-1:0] RING_LAST = RCNT_W'(RING_SECONDS - 1);

  if (NUM_ALARMS < 2 || NUM_ALARMS > 8 || RING_SECONDS < 1 || SNOOZE_MIN < 1) begin : g_bad_cfg
    $error("alarm_bank: parameter out of range");
  end

  state_t                            state;
  logic [NUM_ALARMS-1:0][HOUR_W-1:0] al_hour;
  logic [NUM_ALARMS-1:0][MIN_W-1:0]  al_min;
  logic [RCNT_W-1:0]                 ring_cnt;
  logic                              hit;
  logic [IDX_W-1:0]                  hit_idx;
  logic                              match;

`ifdef ALARM_SNOOZE_EN
  localparam int SCNT_W = $clog2(SNOOZE_MIN * 60 + 1);
  localparam logic [SCNT_W-1:0] SNZ_LAST = SCNT_W'(SNOOZE_MIN * 60 - 1);
  logic [SCNT_W-1:0] snz_cnt;
`endif

  alarm_bank_match #(.NUM_ALARMS(NUM_ALARMS), .IDX_W(IDX_W)) u_match (
    .al_hour (al_hour),
    .al_min  (al_min),
    .en      (bus.alarm_en),
    .hour    (bus.hour),
    .minute  (bus.minute),
    .hit     (hit),
    .idx     (hit_idx)
  );

  // Alarms fire only from IDLE, on the top-of-minute tick.
  assign match = (state == IDLE) && bus.sec_tick && (bus.second == '0) && hit;

  // Controller FSM; all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      al_hour         <= '0;
      al_min          <= '0;
      ring_cnt        <= '0;
      bus.ring        <= 1'b0;
      bus.ring_idx    <= '0;
      bus.sel_idx     <= '0;
      bus.alarm_en    <= '0;
      bus.edit_active <= 1'b0;
      bus.edit_field  <= 1'b0;
      bus.edit_hour   <= '0;
      bus.edit_minute <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state        <= RINGING;
            bus.ring     <= 1'b1;
            bus.ring_idx <= hit_idx;
            ring_cnt     <= '0;
          end else if (bus.middle) begin
            state           <= EDIT_H;
            bus.edit_active <= 1'b1;
            bus.edit_field  <= 1'b0;
            bus.edit_hour   <= al_hour[bus.sel_idx];
            bus.edit_minute <= al_min[bus.sel_idx];
          end else if (bus.up) begin
            bus.alarm_en[bus.sel_idx] <= ~bus.alarm_en[bus.sel_idx];
          end else if (!bus.down) begin
            // down has no action here but still consumes the cycle
            if (bus.left)
              bus.sel_idx <= (bus.sel_idx == '0) ? LAST_IDX : bus.sel_idx - 1'b1;
            else if (bus.right)
              bus.sel_idx <= (bus.sel_idx == LAST_IDX) ? '0 : bus.sel_idx + 1'b1;
          end
        end

        EDIT_H, EDIT_M: begin
          if (bus.middle) begin
            al_hour[bus.sel_idx]      <= bus.edit_hour;
            al_min[bus.sel_idx]       <= bus.edit_minute;
            bus.alarm_en[bus.sel_idx] <= 1'b1;
            state                     <= IDLE;
            bus.edit_active           <= 1'b0;
            bus.edit_field            <= 1'b0;
          end else if (bus.up || bus.down) begin
            if (state == EDIT_H)
              bus.edit_hour <= HOUR_W'(step_wrap(MIN_W'(bus.edit_hour),
                                                 MIN_W'(HOUR_MAX), !bus.up));
            else
              bus.edit_minute <= step_wrap(bus.edit_minute, MIN_W'(MIN_MAX), !bus.up);
          end else if (bus.left) begin
            if (state == EDIT_M) begin
              state          <= EDIT_H;
              bus.edit_field <= 1'b0;
            end
          end else if (bus.right) begin
            if (state == EDIT_H) begin
              state          <= EDIT_M;
              bus.edit_field <= 1'b1;
            end
          end
        end

        RINGING: begin
          if (bus.middle) begin
            state    <= IDLE;
            bus.ring <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (bus.up || bus.down) begin
            state    <= SNOOZE;
            bus.ring <= 1'b0;
            snz_cnt  <= '0;
`endif
          end else if (bus.sec_tick) begin
            if (ring_cnt == RING_LAST) begin
              state    <= IDLE;
              bus.ring <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 1'b1;
            end
          end
        end

`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (bus.middle) begin
            state <= IDLE;
          end else if (bus.sec_tick) begin
            if (snz_cnt == SNZ_LAST) begin
              state    <= RINGING;
              bus.ring <= 1'b1;
              ring_cnt <= '0;
            end else begin
              snz_cnt <= snz_cnt + 1'b1;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: table-driven edit/select vectors plus
// hand-written ringing, priority, snooze and reset sequences.
module tb_alarm_bank;
  import alarm_bank_pkg::*;

  localparam int BN = 0, BU = 1, BD = 2, BL = 3, BR = 4, BM = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alarm_bank_if #(.NUM_ALARMS(4)) bus ();

  alarm_bank #(.NUM_ALARMS(4), .RING_SECONDS(60), .SNOOZE_MIN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         btn;
    int         reps;
    logic       ring;
    logic [1:0] sel;
    logic [3:0] en;
    logic       ea;
    logic       ef;
    logic [4:0] eh;
    logic [5:0] em;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(int b, int r, logic [1:0] sel, logic [3:0] en,
                              logic ea, logic ef, logic [4:0] eh, logic [5:0] em);
    vec_t v;
    v.btn = b; v.reps = r; v.ring = 1'b0; v.sel = sel; v.en = en;
    v.ea = ea; v.ef = ef; v.eh = eh; v.em = em;
    return v;
  endfunction

  function automatic logic [19:0] obs();
    return {bus.ring, bus.sel_idx, bus.alarm_en, bus.edit_active, bus.edit_field,
            bus.edit_hour, bus.edit_minute};
  endfunction

  function automatic logic [19:0] pack_exp(vec_t v);
    return {v.ring, v.sel, v.en, v.ea, v.ef, v.eh, v.em};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(int b);
    bus.up     = (b == BU);
    bus.down   = (b == BD);
    bus.left   = (b == BL);
    bus.right  = (b == BR);
    bus.middle = (b == BM);
  endtask

  task automatic press(int b, int n);
    repeat (n) begin
      set_btn(b);
      cyc();
      set_btn(BN);
    end
  endtask

  task automatic tick(int h, int m, int s);
    bus.hour     = 5'(h);
    bus.minute   = 6'(m);
    bus.second   = 6'(s);
    bus.sec_tick = 1'b1;
    cyc();
    bus.sec_tick = 1'b0;
  endtask

  initial begin
    bus.sec_tick = 1'b0;
    bus.hour = '0; bus.minute = '0; bus.second = '0;
    set_btn(BN);
    rst_n = 1'b0;
    cyc(); cyc();
    chk("reset_outputs", 32'(obs()), 32'h0);
    chk("reset_ring_idx", 32'(bus.ring_idx), 32'h0);
    rst_n = 1'b1;

    // select alarm 1, program 07:30 with wrap checks on both fields, then navigate
    vecs[0]  = mk(BR, 1,  2'd1, 4'b0000, 1'b0, 1'b0, 5'd0,  6'd0);
    vecs[1]  = mk(BM, 1,  2'd1, 4'b0000, 1'b1, 1'b0, 5'd0,  6'd0);
    vecs[2]  = mk(BD, 1,  2'd1, 4'b0000, 1'b1, 1'b0, 5'd23, 6'd0);
    vecs[3]  = mk(BU, 1,  2'd1, 4'b0000, 1'b1, 1'b0, 5'd0,  6'd0);
    vecs[4]  = mk(BU, 7,  2'd1, 4'b0000, 1'b1, 1'b0, 5'd7,  6'd0);
    vecs[5]  = mk(BR, 1,  2'd1, 4'b0000, 1'b1, 1'b1, 5'd7,  6'd0);
    vecs[6]  = mk(BD, 1,  2'd1, 4'b0000, 1'b1, 1'b1, 5'd7,  6'd59);
    vecs[7]  = mk(BU, 1,  2'd1, 4'b0000, 1'b1, 1'b1, 5'd7,  6'd0);
    vecs[8]  = mk(BU, 30, 2'd1, 4'b0000, 1'b1, 1'b1, 5'd7,  6'd30);
    vecs[9]  = mk(BL, 1,  2'd1, 4'b0000, 1'b1, 1'b0, 5'd7,  6'd30);
    vecs[10] = mk(BR, 1,  2'd1, 4'b0000, 1'b1, 1'b1, 5'd7,  6'd30);
    vecs[11] = mk(BM, 1,  2'd1, 4'b0010, 1'b0, 1'b0, 5'd7,  6'd30);
    vecs[12] = mk(BL, 1,  2'd0, 4'b0010, 1'b0, 1'b0, 5'd7,  6'd30);
    vecs[13] = mk(BL, 1,  2'd3, 4'b0010, 1'b0, 1'b0, 5'd7,  6'd30);
    vecs[14] = mk(BR, 1,  2'd0, 4'b0010, 1'b0, 1'b0, 5'd7,  6'd30);
    vecs[15] = mk(BU, 1,  2'd0, 4'b0011, 1'b0, 1'b0, 5'd7,  6'd30);
    vecs[16] = mk(BU, 1,  2'd0, 4'b0010, 1'b0, 1'b0, 5'd7,  6'd30);

    for (int i = 0; i < 17; i++) begin
      press(vecs[i].btn, vecs[i].reps);
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(pack_exp(vecs[i])));
    end

    // alarm 1 at 07:30:00, with a same-cycle right press that must be dropped
    bus.right = 1'b1;
    tick(7, 30, 0);
    bus.right = 1'b0;
    chk("ring_rise", 32'(bus.ring), 32'd1);
    chk("ring_idx_1", 32'(bus.ring_idx), 32'd1);
    chk("match_beats_button", 32'(bus.sel_idx), 32'd0);
    for (int s = 1; s < 60; s++) tick(7, 30, s);
    chk("ring_tick59", 32'(bus.ring), 32'd1);
    tick(7, 31, 0);
    chk("ring_timeout", 32'(bus.ring), 32'd0);
    chk("en_kept", 32'(bus.alarm_en), 32'b0010);

    // alarms 0 and 2 both at 06:00
    press(BM, 1); press(BU, 6); press(BM, 1);
    press(BR, 2);
    press(BM, 1); press(BU, 6); press(BM, 1);
    chk("en_three", 32'(bus.alarm_en), 32'b0111);
    tick(6, 0, 0);
    chk("lowest_ring", 32'(bus.ring), 32'd1);
    chk("lowest_idx", 32'(bus.ring_idx), 32'd0);
    press(BM, 1);
    chk("middle_stop", 32'(bus.ring), 32'd0);
    tick(6, 0, 1);
    chk("no_second_ring", 32'(bus.ring), 32'd0);

    // match during edit is ignored
    press(BM, 1);
    tick(6, 1, 0);
    tick(6, 0, 0);
    chk("edit_no_ring", {bus.ring, bus.edit_active}, 32'b01);
    press(BM, 1);

    // snooze behaviour on alarm 1
    tick(7, 30, 0);
    chk("ring_again", {bus.ring, bus.ring_idx}, {29'd0, 1'b1, 2'd1});
    press(BU, 1);
`ifdef ALARM_SNOOZE_EN
    chk("snooze_off", 32'(bus.ring), 32'd0);
    for (int s = 0; s < 59; s++) tick(12, 0, s);
    chk("snooze_tick59", 32'(bus.ring), 32'd0);
    tick(12, 0, 59);
    chk("snooze_rering", {bus.ring, bus.ring_idx}, {29'd0, 1'b1, 2'd1});
`else
    chk("up_ignored", 32'(bus.ring), 32'd1);
`endif
    press(BM, 1);
    chk("ring_cleared", 32'(bus.ring), 32'd0);

    // reset in the middle of EDIT_M
    press(BM, 1); press(BR, 1);
    chk("in_edit_m", {bus.edit_active, bus.edit_field}, 32'b11);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("midedit_reset", 32'(obs()), 32'h0);
    press(BM, 1);
    chk("alarm0_cleared", 32'(obs()), 32'(20'b0_00_0000_1_0_00000_000000));
    press(BM, 1);
    tick(6, 0, 0);
    chk("no_ring_after_reset", 32'(bus.ring), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
